// File: rtl/eth_rx_ctrl.sv
// Ethernet RX sequencer: launches the receiver, buffers payload speculatively and commits or rolls back per frame.
// Payload appears on m_* one cycle after commit; m_ready stalls reads only. Optional ETH_RX_CTRL_STATS_EN adds frame counters.
module eth_rx_ctrl #(
   parameter int DEPTH      = 64,
   parameter int TIMEOUT    = 4096,
   parameter int RST_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       line_sof,
   output logic       rx_start,
   output logic       rx_rst,
   input  logic       rx_rdy,
   input  logic       rx_vld,
   input  logic [7:0] rx_out,
   output logic [7:0] m_data,
   output logic       m_last,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       busy,
   output logic       frame_ok,
   output logic       frame_drop
`ifdef ETH_RX_CTRL_STATS_EN
   ,
   input  logic        cnt_clr,
   output logic [15:0] cnt_ok,
   output logic [15:0] cnt_drop,
   output logic [15:0] cnt_timeout
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int RW = $clog2(RST_CYCLES + 1);
   localparam logic [AW:0]   CAP      = (AW + 1)'(DEPTH - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, START, RECV, EVAL, ABORT} state_t;

   state_t        state_q, state_d;
   logic [15:0]   cnt_q, cnt_d, len_q, len_d;
   logic [TW-1:0] cyc_q, cyc_d;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic          prev_vld_q, prev_vld_d, rdy_prev_q, rdy_prev_d, ovf_q, ovf_d;
   logic [7:0]    prev_out_q, prev_out_d;
   logic [AW:0]   spec_wptr_q, spec_wptr_d, cwptr_q, cwptr_d, rptr_q, rptr_d;
   logic          wr_en, frame_end;
   logic [8:0]    wr_dat, rd_word;
   logic [16:0]   idx17, len17;
   logic [AW:0]   occ;
   logic [8:0]    mem [DEPTH];

   assign frame_end = rx_rdy & ~rdy_prev_q;
   assign idx17     = {1'b0, cnt_q};
   assign len17     = {1'b0, len_q};
   // Occupancy counts speculative entries too, so an uncommitted frame cannot overrun unread data.
   assign occ       = spec_wptr_q - rptr_q;
   assign rd_word   = mem[rptr_q[AW-1:0]];
   assign m_valid   = (rptr_q != cwptr_q);
   assign m_data    = m_valid ? rd_word[7:0] : 8'h00;
   assign m_last    = m_valid & rd_word[8];
   assign busy      = (state_q != IDLE);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      cyc_d       = cyc_q;
      rcnt_d      = rcnt_q;
      prev_vld_d  = prev_vld_q;
      prev_out_d  = prev_out_q;
      rdy_prev_d  = rx_rdy;
      ovf_d       = ovf_q;
      spec_wptr_d = spec_wptr_q;
      cwptr_d     = cwptr_q;
      rptr_d      = (m_valid & m_ready) ? rptr_q + 1'b1 : rptr_q;
      wr_en       = 1'b0;
      wr_dat      = 9'h000;
      rx_start    = 1'b0;
      rx_rst      = 1'b0;
      frame_ok    = 1'b0;
      frame_drop  = 1'b0;
      case (state_q)
         IDLE: begin
            ovf_d = 1'b0;
            if (line_sof & rx_rdy) begin
               state_d    = START;
               cnt_d      = 16'h0000;
               len_d      = 16'h0000;
               cyc_d      = '0;
               prev_vld_d = 1'b0;
               prev_out_d = 8'h00;
            end
         end
         START: begin
            rx_start = 1'b1;
            state_d  = RECV;
         end
         RECV: begin
            cyc_d = cyc_q + 1'b1;
            if (frame_end) begin
               state_d = EVAL;
            end else if (cyc_q == TO_LAST) begin
               state_d = ABORT;
               rcnt_d  = '0;
            end else begin
               prev_vld_d = rx_vld;
               prev_out_d = rx_out;
               if (rx_vld) begin
                  if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                  if (cnt_q == 16'd0) begin
                     len_d[15:8] = rx_out;
                  end else if (cnt_q == 16'd1) begin
                     len_d[7:0] = rx_out;
                  end else if ((idx17 - 17'd2) < len17) begin
                     if (ovf_q || occ == CAP) begin
                        ovf_d = 1'b1;
                     end else begin
                        wr_en       = 1'b1;
                        wr_dat      = {(idx17 == len17 + 17'd1), rx_out};
                        spec_wptr_d = spec_wptr_q + 1'b1;
                     end
                  end
               end
            end
         end
         EVAL: begin
            state_d = IDLE;
            // Length octets + payload + 4 trailer octets, the last of which is the status.
            if (prev_vld_q && prev_out_q == 8'h00 && idx17 == len17 + 17'd6 && !ovf_q) begin
               frame_ok = 1'b1;
               cwptr_d  = spec_wptr_q;
            end else begin
               frame_drop  = 1'b1;
               spec_wptr_d = cwptr_q;
            end
         end
         ABORT: begin
            rx_rst      = 1'b1;
            frame_drop  = (rcnt_q == '0);
            spec_wptr_d = cwptr_q;
            rcnt_d      = rcnt_q + 1'b1;
            if (rcnt_q == RST_LAST) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 16'h0000;
         len_q       <= 16'h0000;
         cyc_q       <= '0;
         rcnt_q      <= '0;
         prev_vld_q  <= 1'b0;
         prev_out_q  <= 8'h00;
         rdy_prev_q  <= 1'b0;
         ovf_q       <= 1'b0;
         spec_wptr_q <= '0;
         cwptr_q     <= '0;
         rptr_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         cyc_q       <= cyc_d;
         rcnt_q      <= rcnt_d;
         prev_vld_q  <= prev_vld_d;
         prev_out_q  <= prev_out_d;
         rdy_prev_q  <= rdy_prev_d;
         ovf_q       <= ovf_d;
         spec_wptr_q <= spec_wptr_d;
         cwptr_q     <= cwptr_d;
         rptr_q      <= rptr_d;
      end
   end

   // Payload storage holds no reset state; m_data is masked while empty.
   always_ff @(posedge clk) begin
      if (wr_en) mem[spec_wptr_q[AW-1:0]] <= wr_dat;
   end

`ifdef ETH_RX_CTRL_STATS_EN
   logic [15:0] cnt_ok_q, cnt_ok_d, cnt_drop_q, cnt_drop_d, cnt_to_q, cnt_to_d;
   logic        abort_entry;

   assign abort_entry = (state_q == ABORT) && (rcnt_q == '0);
   assign cnt_ok      = cnt_ok_q;
   assign cnt_drop    = cnt_drop_q;
   assign cnt_timeout = cnt_to_q;

   always_comb begin
      cnt_ok_d   = cnt_ok_q;
      cnt_drop_d = cnt_drop_q;
      cnt_to_d   = cnt_to_q;
      if (cnt_clr) begin
         cnt_ok_d   = 16'h0000;
         cnt_drop_d = 16'h0000;
         cnt_to_d   = 16'h0000;
      end else begin
         if (frame_ok && cnt_ok_q != 16'hFFFF)     cnt_ok_d   = cnt_ok_q + 16'd1;
         if (frame_drop && cnt_drop_q != 16'hFFFF) cnt_drop_d = cnt_drop_q + 16'd1;
         if (abort_entry && cnt_to_q != 16'hFFFF)  cnt_to_d   = cnt_to_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_ok_q   <= 16'h0000;
         cnt_drop_q <= 16'h0000;
         cnt_to_q   <= 16'h0000;
      end else begin
         cnt_ok_q   <= cnt_ok_d;
         cnt_drop_q <= cnt_drop_d;
         cnt_to_q   <= cnt_to_d;
      end
   end
`endif
endmodule

// File: doc/eth_rx_ctrl.md
Name: eth_rx_ctrl

Overview:
- Sequencing controller for the Ethernet frame receiver datapath.
- Launches the receiver on each line start-of-frame and captures its octet stream. Buffers payload speculatively, then commits it on a success terminator or rolls it back on error, MAC drop, overflow or timeout.
- Sits between the receiver and the downstream payload consumer; exposes a valid/ready stream with a last flag.

Parameters:
- DEPTH, 64, payload buffer entries (power of 2, >=8).
- TIMEOUT, 4096, max cycles in RECV before abort (>=16).
- RST_CYCLES, 2, cycles rx_rst is held on abort.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- line_sof  in  1  start-of-frame indication from line side
- rx_start  out  1  start pulse to receiver
- rx_rst  out  1  sync active-high reset to receiver
- rx_rdy  in  1  receiver idle
- rx_vld  in  1  receiver octet valid
- rx_out  in  8  receiver octet
- m_data  out  8  payload octet
- m_last  out  1  final octet of frame
- m_valid  out  1  payload valid
- m_ready  in  1  consumer ready
- busy  out  1  state != IDLE
- frame_ok  out  1  1-cycle pulse on commit
- frame_drop  out  1  1-cycle pulse on rollback/abort

Behaviour:
- Reset (async assert, sync deassert): FSM IDLE; pointers 0; rx_start=0, rx_rst=0, m_valid=0, m_last=0, m_data=0, busy=0, frame_ok=0, frame_drop=0.
- Receiver stream contract:
  - Octets with rx_vld: 2 length octets L (big-endian), L payload, 4 trailer.
  - Frame end = rx_rdy 0->1 transition. Status octet = rx_out of the cycle immediately before that transition, valid only if rx_vld was 1 in that cycle. 0x00 = success; anything else = error.
- FSM:
  - IDLE: line_sof & rx_rdy -> START. line_sof while !rx_rdy is ignored.
  - START: rx_start=1 for exactly 1 cycle -> RECV.
  - RECV:
    - Count vld octets (16-bit, saturating).
    - Octets 0-1 latch L.
    - Octets 2..L+1 written at speculative wptr, with last bit set on octet L+1. Other octets are not stored.
    - Register prev rx_vld/rx_out each cycle.
    - On frame end -> EVAL.
    - Cycle counter reaching TIMEOUT -> ABORT.
  - EVAL (1 cycle):
    - COMMIT when: prev vld & status==0x00 & count==L+6 (includes status octet) & no overflow. Then committed_wptr <= spec_wptr and frame_ok=1.
    - Otherwise rollback: spec_wptr <= committed_wptr and frame_drop=1.
    - -> IDLE.
  - ABORT: rx_rst=1 for RST_CYCLES; rollback; frame_drop=1 on entry -> IDLE.
- L==0 with success: commit with nothing written; frame_ok pulses; no output.
- Overflow: spec_wptr would reach rptr (full, one slot reserved) -> stop writing, set overflow flag, frame is dropped at EVAL. The flag clears on IDLE.
- Read side:
  - m_valid = (rptr != committed_wptr); m_data/m_last come from the registered buffer at rptr.
  - Advance rptr on m_valid & m_ready.
  - Rollback never moves rptr. Reads and writes in the same cycle are legal.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full/empty are derived from the MSB.
- rx_vld outside RECV is ignored.
- rst_n mid-frame discards all buffered data, including committed data.

Optional Feature:
- Macro ETH_RX_CTRL_STATS_EN.
- Defined:
  - Adds outputs cnt_ok[15:0], cnt_drop[15:0], cnt_timeout[15:0]. Each is a saturating counter incremented on frame_ok, frame_drop and ABORT entry respectively.
  - Adds input cnt_clr (sync clear; wins over a same-cycle increment).
  - All counters reset to 0.
- Undefined: these ports and counters are absent.

Test Plan:
- Good frame: line_sof; stream 00 03 11 22 33 + 4 trailer + 00, then rx_rdy rises -> rx_start pulse 1 cycle after line_sof; frame_ok; m_data 11,22,33 with m_last on 33.
- Error terminator F4 -> frame_drop; no m_valid; a following good frame emits only its own payload.
- MAC drop: rx_rdy returns with no vld cycle before it -> frame_drop; no data.
- Timeout: rx_rdy held 0 for TIMEOUT cycles -> rx_rst high 2 cycles, frame_drop, IDLE.
- Overflow with DEPTH=8 and m_ready=0: L=10 good frame -> dropped. Earlier committed 3-octet frame still reads intact.
- Backpressure: toggle m_ready during a commit of a second frame -> order preserved, no loss or duplication; rst_n pulse mid-RECV -> all outputs return to reset values.
